// File: rtl/breakout_game_fsm_pkg.sv
// Shared definitions for the breakout game-flow controller and the playfield
// logic that consumes its state and brick count.
package breakout_game_fsm_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT     = 3'd0,
    ST_SERVE       = 3'd1,
    ST_PLAY        = 3'd2,
    ST_BALL_LOST   = 3'd3,
    ST_LEVEL_CLEAR = 3'd4,
    ST_GAME_OVER   = 3'd5
  } game_state_e;

  localparam int unsigned BRICK_COUNT_DEFAULT = 128;
  localparam int unsigned BOTTOM_Y_DEFAULT    = 232;

  localparam int unsigned TIMER_W = 8;

  // True in the states that park the ball at the serve position.
  function automatic logic holds_ball(input game_state_e s);
    return (s == ST_ATTRACT) || (s == ST_SERVE) || (s == ST_GAME_OVER);
  endfunction

endpackage

// File: rtl/breakout_game_fsm_frame_timer.sv
// Frame-count down timer: loaded on state entry, decremented on frame ticks,
// flags expiry on the tick that takes it from 1 to 0.
import breakout_game_fsm_pkg::*;

module breakout_game_fsm_frame_timer (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               tick_i,
  output logic               expire_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- that is what keeps latches from being inferred.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      // A zero load would never expire; treat it as a single frame.
      count_d = (load_val_i == '0) ? TIMER_W'(1) : load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expire_o = tick_i && (count_q == TIMER_W'(1));

endmodule

// File: rtl/breakout_game_fsm.sv
// Game-flow controller for the brick/paddle game: sequences attract, serve,
// play, ball-lost, level-clear and game-over, and drives the related pulses.
import breakout_game_fsm_pkg::*;

module breakout_game_fsm #(
  parameter int unsigned BRICK_COUNT     = BRICK_COUNT_DEFAULT,
  parameter int unsigned SERVE_DELAY     = 60,
  parameter int unsigned LOST_FRAMES     = 90,
  parameter int unsigned GAMEOVER_FRAMES = 180,
  parameter int unsigned BOTTOM_Y        = BOTTOM_Y_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick_i,
  input  logic       start_i,
  input  logic [8:0] ball_y_i,
  input  logic       brick_hit_i,
  input  logic [3:0] lives_i,
  output logic       declives_o,
  output logic       stats_reset_o,
  output logic       bricks_clear_o,
  output logic       ball_reset_o,
  output logic       ball_enable_o,
  output logic [2:0] state_o,
  output logic [7:0] bricks_left_o
);

  localparam logic [7:0]         BRICK_LOAD = 8'(BRICK_COUNT);
  localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_DELAY);
  localparam logic [TIMER_W-1:0] LOST_LOAD  = TIMER_W'(LOST_FRAMES);
  localparam logic [TIMER_W-1:0] OVER_LOAD  = TIMER_W'(GAMEOVER_FRAMES);
  localparam logic [8:0]         BOTTOM_LIM = 9'(BOTTOM_Y);

  game_state_e state_q, state_d;
  logic [7:0]  bricks_left_q, bricks_left_d;
  logic        declives_q, declives_d;
  logic        stats_reset_q, stats_reset_d;
  logic        bricks_clear_q, bricks_clear_d;
  logic        ball_reset_q, ball_enable_q;

  logic start_meta_q, start_sync_q, start_prev_q;
  logic start_edge;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_expire;

  logic [7:0] bricks_dec;
  logic       ball_out;

  // Raw button is asynchronous: two flops before anything looks at it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      start_meta_q <= start_i;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
    end
  end

  assign start_edge = start_sync_q && !start_prev_q;

  breakout_game_fsm_frame_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_i     (frame_tick_i),
    .expire_o   (tmr_expire)
  );

  assign bricks_dec = (bricks_left_q == '0) ? '0 : bricks_left_q - 8'd1;
  assign ball_out   = frame_tick_i && (ball_y_i >= BOTTOM_LIM);

  always_comb begin
    state_d        = state_q;
    bricks_left_d  = bricks_left_q;
    declives_d     = 1'b0;
    stats_reset_d  = 1'b0;
    bricks_clear_d = 1'b0;
    tmr_load       = 1'b0;
    tmr_val        = '0;

    unique case (state_q)
      ST_ATTRACT: begin
        if (start_edge) begin
          stats_reset_d  = 1'b1;
          bricks_clear_d = 1'b1;
          bricks_left_d  = BRICK_LOAD;
          state_d        = ST_SERVE;
          tmr_load       = 1'b1;
          tmr_val        = SERVE_LOAD;
        end
      end
      ST_SERVE: begin
        if (tmr_expire) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (brick_hit_i) bricks_left_d = bricks_dec;
        // Clearing the last brick outranks a ball loss in the same clk.
        if (brick_hit_i && (bricks_dec == '0)) begin
          state_d  = ST_LEVEL_CLEAR;
          tmr_load = 1'b1;
          tmr_val  = LOST_LOAD;
        end else if (ball_out) begin
          declives_d = 1'b1;
          state_d    = ST_BALL_LOST;
          tmr_load   = 1'b1;
          tmr_val    = LOST_LOAD;
        end
      end
      ST_BALL_LOST: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (lives_i == '0) begin
            state_d = ST_GAME_OVER;
            tmr_val = OVER_LOAD;
          end else begin
            state_d = ST_SERVE;
            tmr_val = SERVE_LOAD;
          end
        end
      end
      ST_LEVEL_CLEAR: begin
        if (tmr_expire) begin
          bricks_clear_d = 1'b1;
          bricks_left_d  = BRICK_LOAD;
          state_d        = ST_SERVE;
          tmr_load       = 1'b1;
          tmr_val        = SERVE_LOAD;
        end
      end
      ST_GAME_OVER: begin
        if (tmr_expire) state_d = ST_ATTRACT;
      end
      default: state_d = ST_ATTRACT;
    endcase
  end

  // Ball controls follow the next state so they change on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_ATTRACT;
      bricks_left_q  <= BRICK_LOAD;
      declives_q     <= 1'b0;
      stats_reset_q  <= 1'b0;
      bricks_clear_q <= 1'b0;
      ball_reset_q   <= 1'b1;
      ball_enable_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      bricks_left_q  <= bricks_left_d;
      declives_q     <= declives_d;
      stats_reset_q  <= stats_reset_d;
      bricks_clear_q <= bricks_clear_d;
      ball_reset_q   <= holds_ball(state_d);
      ball_enable_q  <= (state_d == ST_PLAY);
    end
  end

  assign declives_o     = declives_q;
  assign stats_reset_o  = stats_reset_q;
  assign bricks_clear_o = bricks_clear_q;
  assign ball_reset_o   = ball_reset_q;
  assign ball_enable_o  = ball_enable_q;
  assign state_o        = state_q;
  assign bricks_left_o  = bricks_left_q;

endmodule

// File: tb/tb_breakout_game_fsm.sv
// Directed bench for the breakout game-flow controller: a vector table walks
// a full game, then hand sequences cover restart and asynchronous reset.
module tb_breakout_game_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, start, brick_hit;
  logic [8:0] ball_y;
  logic [3:0] lives;
  logic       declives, stats_reset, bricks_clear, ball_reset, ball_enable;
  logic [2:0] state;
  logic [7:0] bricks_left;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  breakout_game_fsm #(
    .BRICK_COUNT     (4),
    .SERVE_DELAY     (3),
    .LOST_FRAMES     (2),
    .GAMEOVER_FRAMES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick_i   (frame_tick),
    .start_i        (start),
    .ball_y_i       (ball_y),
    .brick_hit_i    (brick_hit),
    .lives_i        (lives),
    .declives_o     (declives),
    .stats_reset_o  (stats_reset),
    .bricks_clear_o (bricks_clear),
    .ball_reset_o   (ball_reset),
    .ball_enable_o  (ball_enable),
    .state_o        (state),
    .bricks_left_o  (bricks_left)
  );

  typedef struct {
    string      name;
    bit         ft, st, bh;
    logic [8:0] by;
    logic [3:0] lv;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Output vector layout: {declives, stats_reset, bricks_clear, ball_reset,
  // ball_enable, state[2:0], bricks_left[7:0]}.
  function automatic logic [15:0] e(input bit dec, sr, bc, br, be,
                                    input logic [2:0] s, input logic [7:0] bl);
    return {dec, sr, bc, br, be, s, bl};
  endfunction

  function automatic logic [15:0] outs();
    return {declives, stats_reset, bricks_clear, ball_reset, ball_enable, state, bricks_left};
  endfunction

  task automatic add(input string nm, input bit ft, st, bh,
                     input logic [8:0] by, input logic [3:0] lv, input logic [15:0] ex);
    vec_t v;
    v.name = nm; v.ft = ft; v.st = st; v.bh = bh; v.by = by; v.lv = lv; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %04h expected %04h", nm, act, ex);
    end
  endtask

  task automatic drive(input bit ft, st, bh, input logic [8:0] by, input logic [3:0] lv);
    frame_tick = ft; start = st; brick_hit = bh; ball_y = by; lives = lv;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;

    // ---- game walk: inputs for one clk, expected outputs after that edge
    add("start_sync1",   0, 1, 0, 100, 2, e(0,0,0,1,0,0,4));
    add("start_sync2",   0, 1, 0, 100, 2, e(0,0,0,1,0,0,4));
    add("start_edge",    0, 1, 0, 100, 2, e(0,1,1,1,0,1,4));
    add("start_pulse_end",0,1, 0, 100, 2, e(0,0,0,1,0,1,4));
    add("hit_in_serve",  0, 0, 1, 100, 2, e(0,0,0,1,0,1,4));
    add("serve_tick1",   1, 0, 0, 100, 2, e(0,0,0,1,0,1,4));
    add("serve_tick2",   1, 0, 0, 100, 2, e(0,0,0,1,0,1,4));
    add("serve_tick3",   1, 0, 0, 100, 2, e(0,0,0,0,1,2,4));
    add("y231_no_loss",  1, 0, 0, 231, 2, e(0,0,0,0,1,2,4));
    add("y240_no_tick",  0, 0, 0, 240, 2, e(0,0,0,0,1,2,4));
    add("ball_lost",     1, 0, 0, 240, 2, e(1,0,0,0,0,3,4));
    add("lost_idle",     0, 0, 0, 100, 2, e(0,0,0,0,0,3,4));
    add("lost_tick1",    1, 0, 0, 100, 2, e(0,0,0,0,0,3,4));
    add("lost_expire",   1, 0, 0, 100, 2, e(0,0,0,1,0,1,4));
    add("reserve_tick1", 1, 0, 0, 100, 2, e(0,0,0,1,0,1,4));
    add("reserve_tick2", 1, 0, 0, 100, 2, e(0,0,0,1,0,1,4));
    add("reserve_tick3", 1, 0, 0, 100, 2, e(0,0,0,0,1,2,4));
    add("hit1",          0, 0, 1, 100, 2, e(0,0,0,0,1,2,3));
    add("hit2",          0, 0, 1, 100, 2, e(0,0,0,0,1,2,2));
    add("hit3",          0, 0, 1, 100, 2, e(0,0,0,0,1,2,1));
    add("last_hit_vs_loss",1,0, 1, 250, 2, e(0,0,0,0,0,4,0));
    add("clear_tick1",   1, 0, 0, 100, 2, e(0,0,0,0,0,4,0));
    add("clear_expire",  1, 0, 0, 100, 2, e(0,0,1,1,0,1,4));
    add("clear_pulse_end",0,0, 0, 100, 2, e(0,0,0,1,0,1,4));
    add("lvl2_tick1",    1, 0, 0, 100, 2, e(0,0,0,1,0,1,4));
    add("lvl2_tick2",    1, 0, 0, 100, 2, e(0,0,0,1,0,1,4));
    add("lvl2_tick3",    1, 0, 0, 100, 2, e(0,0,0,0,1,2,4));
    add("final_loss",    1, 0, 0, 240, 0, e(1,0,0,0,0,3,4));
    add("final_tick1",   1, 0, 0, 100, 0, e(0,0,0,0,0,3,4));
    add("to_game_over",  1, 0, 0, 100, 0, e(0,0,0,1,0,5,4));
    add("go_start1",     0, 1, 0, 100, 0, e(0,0,0,1,0,5,4));
    add("go_start2",     0, 1, 0, 100, 0, e(0,0,0,1,0,5,4));
    add("go_start_edge", 0, 1, 0, 100, 0, e(0,0,0,1,0,5,4));
    add("go_tick1",      1, 1, 0, 100, 0, e(0,0,0,1,0,5,4));
    add("go_expire",     1, 1, 0, 100, 0, e(0,0,0,1,0,0,4));
    add("attract_held",  0, 1, 0, 100, 0, e(0,0,0,1,0,0,4));

    reset = 1'b1;
    drive(0, 0, 0, 9'd100, 4'd2);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), e(0,0,0,1,0,0,4));
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ft, vecs[i].st, vecs[i].bh, vecs[i].by, vecs[i].lv);
      cyc();
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // ---- restart: release start, press again, wait (bounded) for the serve
    drive(0, 0, 0, 9'd100, 4'd3);
    repeat (3) cyc();
    start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      cyc();
      if (stats_reset) found = 1'b1;
    end
    check("restart_seen", {15'd0, found}, 16'd1);
    check("restart_serve", outs(), e(0,1,1,1,0,1,4));

    // Ticks until PLAY, bounded.
    frame_tick = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      cyc();
      if (state == 3'd2) found = 1'b1;
    end
    check("restart_play_seen", {15'd0, found}, 16'd1);
    frame_tick = 1'b0;
    brick_hit  = 1'b1;
    cyc();
    brick_hit  = 1'b0;
    check("mid_play_hit", outs(), e(0,0,0,0,1,2,3));

    // ---- asynchronous reset between clock edges
    #3 reset = 1'b1;
    #1;
    check("async_reset", outs(), e(0,0,0,1,0,0,4));
    cyc();
    reset = 1'b0;
    cyc();
    check("after_reset", outs(), e(0,0,0,1,0,0,4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/breakout_game_fsm.md
Name: breakout_game_fsm

Overview:
- Game-flow controller for the brick/paddle game; sits between the playfield/collision logic and the player stats/scoreboard.
- Consumes a per-frame tick, ball Y position, brick-destroyed pulses, the start button, and the lives count from player stats.
- Produces the declives pulse, ball hold/freeze controls, brick-array clear and stats reset requests, and the current game state.
- Fully synchronous to clk; the frame tick replaces vsync-edge clocking.

Parameters:
- BRICK_COUNT, 128, bricks per level; reload value of bricks_left.
- SERVE_DELAY, 60, frames the ball is held at the serve position before play starts. A value of 0 behaves as 1.
- LOST_FRAMES, 90, freeze frames after a ball loss or a level clear.
- GAMEOVER_FRAMES, 180, frames spent in GAME_OVER before returning to ATTRACT.
- BOTTOM_Y, 232, ball_y threshold at or above which the ball counts as lost.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-clk pulse per frame, asserted at the vsync rising edge
- start  in  1  raw start button, level, asynchronous
- ball_y  in  9  current ball Y position
- brick_hit  in  1  one-clk pulse per destroyed brick
- lives  in  4  lives remaining, from player stats
- declives  out  1  one-clk pulse: decrement lives
- stats_reset  out  1  one-clk pulse: reload score/lives
- bricks_clear  out  1  one-clk pulse: re-arm all bricks
- ball_reset  out  1  level: hold ball at the serve position
- ball_enable  out  1  level: ball motion permitted
- state  out  3  current state encoding
- bricks_left  out  8  bricks remaining in the current level

Behaviour:
- Reset values:
  - state=ATTRACT; all pulse outputs 0; ball_reset=1; ball_enable=0.
  - bricks_left=BRICK_COUNT; frame timer=0; start synchronizer=0.
  - Reset mid-game aborts immediately to ATTRACT with no pulses emitted.
- start input: 2-FF synchronizer, then a rising-edge detector; only the edge is used.
- State encodings: ATTRACT=0, SERVE=1, PLAY=2, BALL_LOST=3, LEVEL_CLEAR=4, GAME_OVER=5. Codes 6 and 7 recover to ATTRACT on the next clk.
- Timer: 8-bit frame timer, loaded on state entry. It decrements only on frame_tick. A state exits on the frame_tick that takes the timer from 1 to 0, i.e. exactly N ticks after entry.
- ATTRACT: ball_reset=1, ball_enable=0. On a start edge: stats_reset and bricks_clear each pulse for 1 clk; bricks_left is reloaded; next state SERVE with timer=SERVE_DELAY.
- SERVE: ball_reset=1, ball_enable=0. On expiry go to PLAY.
- PLAY: ball_reset=0, ball_enable=1.
  - brick_hit decrements bricks_left; the decrement saturates at 0.
  - If the decremented value is 0, go to LEVEL_CLEAR with timer=LOST_FRAMES.
  - On a frame_tick with ball_y >= BOTTOM_Y (unsigned 9-bit compare): pulse declives for 1 clk and go to BALL_LOST with timer=LOST_FRAMES.
  - If the last brick_hit and ball loss fall in the same clk, LEVEL_CLEAR wins and declives is not pulsed.
- BALL_LOST: ball_reset=0, ball_enable=0 (ball frozen). On expiry, sample lives:
  - lives==0: go to GAME_OVER with timer=GAMEOVER_FRAMES.
  - otherwise: go to SERVE with timer=SERVE_DELAY.
- LEVEL_CLEAR: ball frozen as in BALL_LOST. On expiry: pulse bricks_clear, reload bricks_left, go to SERVE. Score and lives are kept.
- GAME_OVER: ball_reset=1, ball_enable=0. Start edges are ignored. On expiry go to ATTRACT.
- Input qualification: brick_hit is ignored outside PLAY. frame_tick and brick_hit in the same clk are both processed.
- Output timing: all outputs are registered, so a pulse appears 1 clk after its triggering event. declives is never asserted outside the PLAY→BALL_LOST transition.

Decomposition:
- Shared package:
  - state encodings (ATTRACT..GAME_OVER);
  - BOTTOM_Y default;
  - BRICK_COUNT default, shared with the brick-array logic.
- One natural sub-module: frame_timer (load value, tick, expire flag).
- Start synchronizer and edge detector stay inline.

Test Plan:
- Parameters for all scenarios: BRICK_COUNT=4, SERVE_DELAY=3, LOST_FRAMES=2, GAMEOVER_FRAMES=2.
- Start from ATTRACT:
  - Stimulus: start edge.
  - Response: stats_reset and bricks_clear each high exactly 1 clk; state=1; after 3 frame_ticks state=2, ball_enable=1.
- Ball loss:
  - Stimulus: in PLAY, lives=2, ball_y=240 at a frame_tick.
  - Response: declives 1 clk, state=3; after 2 ticks state=1. Repeat with ball_y=231: no transition.
- Game over:
  - Stimulus: in BALL_LOST with lives=0 at expiry.
  - Response: state=5; a start edge during state 5 is ignored; after 2 ticks state=0.
- Level clear:
  - Stimulus: 4 brick_hit pulses in PLAY.
  - Response: bricks_left 4→0, state=4; after 2 ticks bricks_clear pulses, bricks_left=4, state=1.
- Same-clk priority:
  - Stimulus: final brick_hit coincident with a frame_tick and ball_y=250.
  - Response: state=4, no declives. Also: brick_hit in SERVE leaves bricks_left unchanged.
- Async reset:
  - Stimulus: reset asserted mid-PLAY between clk edges.
  - Response: immediately state=0, ball_reset=1, ball_enable=0, bricks_left=4, all pulses 0.
